sync_down_timer: RTL and testbench



---
 rtl/sync_down_timer_if.sv | 24 ++
 rtl/sync_down_timer.sv | 76 +++++++
 tb/tb_sync_down_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sync_down_timer_if.sv
// Control/status bundle for sync_down_timer: the driver owns the strobes and the
// timer owns the count and flags.
interface sync_down_timer_if #(
   parameter int unsigned WIDTH = 3
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             auto_reload;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             tc;
   logic             zero;

   modport master (
      output en, load, load_val, auto_reload,
      input  q, busy, tc, zero
   );

   modport slave (
      input  en, load, load_val, auto_reload,
      output q, busy, tc, zero
   );
endinterface

// File: rtl/sync_down_timer.sv
// Loadable down-counter with one-shot and auto-reload modes.
// Emits a one-cycle terminal-count pulse on each 1->0 (or 1->reload) step.
module sync_down_timer #(
   parameter int unsigned WIDTH = 3
) (
   input logic              clk,
   input logic              rst,
   sync_down_timer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r, state_n;
   logic [WIDTH-1:0] q_r, q_n;
   logic [WIDTH-1:0] reload_r, reload_n;
   logic             busy_r, busy_n;
   logic             tc_r, tc_n;

   // State and output registers; reset overrides every strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         q_r      <= '0;
         reload_r <= '0;
         busy_r   <= 1'b0;
         tc_r     <= 1'b0;
      end else begin
         state_r  <= state_n;
         q_r      <= q_n;
         reload_r <= reload_n;
         busy_r   <= busy_n;
         tc_r     <= tc_n;
      end
   end

   // Next-state and next-output logic; load takes priority over counting.
   always_comb begin
      state_n  = state_r;
      q_n      = q_r;
      reload_n = reload_r;
      tc_n     = 1'b0;

      if (bus.load) begin
         q_n      = bus.load_val;
         reload_n = bus.load_val;
         state_n  = (bus.load_val != '0) ? RUN : IDLE;
      end else if (state_r == RUN && bus.en) begin
         if (q_r > WIDTH'(1)) begin
            q_n = q_r - WIDTH'(1);
         end else if (q_r == WIDTH'(1)) begin
            tc_n = 1'b1;
            if (bus.auto_reload) begin
               q_n = reload_r;
            end else begin
               q_n     = '0;
               state_n = DONE;
            end
         end else begin
            // A zero count while running is unreachable; park safely without wrapping.
            state_n = IDLE;
         end
      end

      busy_n = (state_n == RUN);
   end

   assign bus.q    = q_r;
   assign bus.busy = busy_r;
   assign bus.tc   = tc_r;
   assign bus.zero = (q_r == '0);

endmodule

// File: tb/tb_sync_down_timer.sv
// Scoreboard bench for sync_down_timer (WIDTH=3): expected outputs are queued as
// each cycle's stimulus is driven and popped after the following clock edge.
module tb_sync_down_timer;

   localparam int unsigned WIDTH = 3;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] q;
      logic             busy;
      logic             tc;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];

   sync_down_timer_if #(.WIDTH(WIDTH)) bus ();

   sync_down_timer #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
   task automatic step(input logic r, input logic ld, input logic [WIDTH-1:0] v,
                       input logic e, input logic ar,
                       input logic [WIDTH-1:0] eq, input logic eb, input logic et,
                       input string tag);
      exp_t x;
      rst             = r;
      bus.load        = ld;
      bus.load_val    = v;
      bus.en          = e;
      bus.auto_reload = ar;
      x.tag  = tag;
      x.q    = eq;
      x.busy = eb;
      x.tc   = et;
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         x = sb.pop_front();
         check({x.tag, "_q"},    32'(bus.q),    32'(x.q));
         check({x.tag, "_busy"}, 32'(bus.busy), 32'(x.busy));
         check({x.tag, "_tc"},   32'(bus.tc),   32'(x.tc));
         check({x.tag, "_zero"}, 32'(bus.zero), 32'(x.q == '0));
      end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      bus.load        = 1'b0;
      bus.load_val    = '0;
      bus.en          = 1'b0;
      bus.auto_reload = 1'b0;

      // Reset holds with load asserted; load must be ignored.
      step(1, 1, 3'd5, 1, 0, 3'd0, 0, 0, "reset0");
      step(1, 1, 3'd5, 1, 0, 3'd0, 0, 0, "reset1");

      // One-shot from 5.
      step(0, 1, 3'd5, 1, 0, 3'd5, 1, 0, "os_load");
      for (int i = 4; i >= 1; i--)
         step(0, 0, 3'd0, 1, 0, 3'(i), 1, 0, "os_count");
      step(0, 0, 3'd0, 1, 0, 3'd0, 0, 1, "os_tc");
      for (int i = 0; i < 10; i++)
         step(0, 0, 3'd0, 1, 0, 3'd0, 0, 0, "os_done_hold");

      // Auto-reload with period 3.
      step(0, 1, 3'd3, 1, 1, 3'd3, 1, 0, "ar_load");
      for (int i = 0; i < 12; i++) begin
         if (i % 3 == 2)
            step(0, 0, 3'd0, 1, 1, 3'd3, 1, 1, "ar_reload");
         else
            step(0, 0, 3'd0, 1, 1, 3'(2 - (i % 3)), 1, 0, "ar_count");
      end

      // Enable gating from 7.
      step(0, 1, 3'd7, 0, 0, 3'd7, 1, 0, "en_load");
      step(0, 0, 3'd0, 1, 0, 3'd6, 1, 0, "en_on0");
      step(0, 0, 3'd0, 0, 0, 3'd6, 1, 0, "en_off0");
      step(0, 0, 3'd0, 0, 0, 3'd6, 1, 0, "en_off1");
      step(0, 0, 3'd0, 1, 0, 3'd5, 1, 0, "en_on1");
      step(0, 0, 3'd0, 1, 0, 3'd4, 1, 0, "en_on2");

      // Restart while running at q=4.
      step(0, 1, 3'd2, 1, 0, 3'd2, 1, 0, "restart");
      step(0, 0, 3'd0, 1, 0, 3'd1, 1, 0, "restart_dec");

      // Reset beats a simultaneous load.
      step(1, 1, 3'd5, 1, 0, 3'd0, 0, 0, "rst_vs_load");

      // Loading zero parks in IDLE; enable has no effect.
      step(0, 1, 3'd0, 1, 0, 3'd0, 0, 0, "load_zero");
      for (int i = 0; i < 3; i++)
         step(0, 0, 3'd0, 1, 0, 3'd0, 0, 0, "idle_en");

      // Full-scale one-shot.
      step(0, 1, 3'd7, 1, 0, 3'd7, 1, 0, "max_load");
      for (int i = 6; i >= 1; i--)
         step(0, 0, 3'd0, 1, 0, 3'(i), 1, 0, "max_count");
      step(0, 0, 3'd0, 1, 0, 3'd0, 0, 1, "max_tc");
      for (int i = 0; i < 3; i++)
         step(0, 0, 3'd0, 1, 0, 3'd0, 0, 0, "max_no_wrap");

      // Reload value of 1 gives tc every enabled cycle.
      step(0, 1, 3'd1, 1, 1, 3'd1, 1, 0, "ar1_load");
      for (int i = 0; i < 5; i++)
         step(0, 0, 3'd0, 1, 1, 3'd1, 1, 1, "ar1_tc");

      // Reset arriving in the tc cycle.
      step(0, 1, 3'd2, 1, 1, 3'd2, 1, 0, "rtc_load");
      step(0, 0, 3'd0, 1, 1, 3'd1, 1, 0, "rtc_dec");
      step(0, 0, 3'd0, 1, 1, 3'd2, 1, 1, "rtc_tc");
      step(1, 0, 3'd0, 1, 1, 3'd0, 0, 0, "rtc_rst");
      step(0, 0, 3'd0, 1, 1, 3'd0, 0, 0, "rtc_after");

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
